// File: rtl/line_way_select_if.sv
// Request/response bundle for line_way_select: way-select request in, selected line out.
// out_parity exists only when LWS_PARITY_EN is defined.
interface line_way_select_if #(
  parameter int LINE_SIZE  = 512,
  parameter int WAYS       = 16,
  parameter int ONEHOT_SEL = 0
);
  localparam int WW   = $clog2(WAYS);
  localparam int SELW = (ONEHOT_SEL != 0) ? WAYS : WW;

  logic                      in_valid;
  logic                      in_ready;
  logic [SELW-1:0]           in_sel;
  logic [WAYS*LINE_SIZE-1:0] in_lines;
  logic                      out_valid;
  logic                      out_ready;
  logic [LINE_SIZE-1:0]      out_line;
  logic [WW-1:0]             out_way;
  logic                      out_err;
`ifdef LWS_PARITY_EN
  logic                      out_parity;
`endif

  modport master (
    output in_valid, in_sel, in_lines, out_ready,
    input  in_ready, out_valid, out_line, out_way, out_err
`ifdef LWS_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_valid, in_sel, in_lines, out_ready,
    output in_ready, out_valid, out_line, out_way, out_err
`ifdef LWS_PARITY_EN
    , output out_parity
`endif
  );
endinterface

// File: rtl/line_way_select.sv
// Registered way selector for the L2 data read path with a 2-entry valid/ready output buffer.
// Optional LWS_PARITY_EN adds a per-entry XOR parity of the selected line on out_parity.
module line_way_select #(
  parameter int LINE_SIZE  = 512,
  parameter int WAYS       = 16,
  parameter int ONEHOT_SEL = 0
) (
  input logic              clk,
  input logic              rst_n,
  line_way_select_if.slave bus
);
  localparam int WW = $clog2(WAYS);

  logic [LINE_SIZE-1:0] selLine;
  logic [WW-1:0]        selWay;
  logic                 selErr;

  // Illegal selects capture an all-zero line and way so the consumer only needs out_err.
  if (ONEHOT_SEL != 0) begin : g_onehot
    always_comb begin
      selLine = '0;
      selWay  = '0;
      selErr  = ($countones(bus.in_sel) != 1);
      for (int w = 0; w < WAYS; w++) begin
        if (bus.in_sel[w]) begin
          selLine = bus.in_lines[w*LINE_SIZE +: LINE_SIZE];
          selWay  = WW'(w);
        end
      end
      if (selErr) begin
        selLine = '0;
        selWay  = '0;
      end
    end
  end else begin : g_binary
    always_comb begin
      selLine = '0;
      selWay  = '0;
      selErr  = (32'(bus.in_sel) >= WAYS);
      if (!selErr) begin
        selLine = bus.in_lines[32'(bus.in_sel)*LINE_SIZE +: LINE_SIZE];
        selWay  = bus.in_sel;
      end
    end
  end

  logic [1:0] count_q, count_d;
  logic       wrPtr_q, wrPtr_d;
  logic       rdPtr_q, rdPtr_d;
  logic       inReady_q, inReady_d;
  logic       push, pop, outValid;

  logic [LINE_SIZE-1:0] lineMem_q [2];
  logic [WW-1:0]        wayMem_q  [2];
  logic                 errMem_q  [2];
`ifdef LWS_PARITY_EN
  logic                 parMem_q  [2];
`endif

  assign outValid = (count_q != 2'd0);
  assign push     = bus.in_valid && inReady_q;
  assign pop      = outValid && bus.out_ready;

  // in_ready comes from a flop so out_ready never reaches it combinationally.
  always_comb begin
    count_d = count_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) begin
      wrPtr_d = ~wrPtr_q;
    end
    if (pop) begin
      rdPtr_d = ~rdPtr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    inReady_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= 2'd0;
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      inReady_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      inReady_q <= inReady_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lineMem_q[wrPtr_q] <= selLine;
      wayMem_q[wrPtr_q]  <= selWay;
      errMem_q[wrPtr_q]  <= selErr;
`ifdef LWS_PARITY_EN
      parMem_q[wrPtr_q]  <= ^selLine;
`endif
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid;
  assign bus.out_line  = outValid ? lineMem_q[rdPtr_q] : '0;
  assign bus.out_way   = outValid ? wayMem_q[rdPtr_q]  : '0;
  assign bus.out_err   = outValid ? errMem_q[rdPtr_q]  : 1'b0;
`ifdef LWS_PARITY_EN
  assign bus.out_parity = outValid ? parMem_q[rdPtr_q] : 1'b0;
`endif

endmodule

// File: tb/tb_line_way_select.sv
// Directed bench for line_way_select: 16-way binary, 12-way binary and 16-way one-hot instances.
// Parity checks are compiled in only when LWS_PARITY_EN is defined.
module tb_line_way_select;
  logic clk;
  logic rst_n;
  int checkCount;
  int errorCount;

  line_way_select_if #(.LINE_SIZE(512), .WAYS(16), .ONEHOT_SEL(0)) busA ();
  line_way_select_if #(.LINE_SIZE(512), .WAYS(12), .ONEHOT_SEL(0)) busB ();
  line_way_select_if #(.LINE_SIZE(512), .WAYS(16), .ONEHOT_SEL(1)) busC ();

  line_way_select #(.LINE_SIZE(512), .WAYS(16), .ONEHOT_SEL(0)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  line_way_select #(.LINE_SIZE(512), .WAYS(12), .ONEHOT_SEL(0)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));
  line_way_select #(.LINE_SIZE(512), .WAYS(16), .ONEHOT_SEL(1)) dutC (.clk(clk), .rst_n(rst_n), .bus(busC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it, where outputs are sampled.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0;
    busA.in_valid = 1'b0; busA.in_sel = '0; busA.out_ready = 1'b1;
    busB.in_valid = 1'b0; busB.in_sel = '0; busB.out_ready = 1'b1;
    busC.in_valid = 1'b0; busC.in_sel = '0; busC.out_ready = 1'b1;
    busA.in_lines = '0;
    busB.in_lines = '0;
    busC.in_lines = '0;
    for (int w = 0; w < 16; w++) begin
      busA.in_lines[w*512 +: 512] = {16{w[31:0]}};
      busC.in_lines[w*512 +: 512] = {16{w[31:0]}};
    end
    for (int w = 0; w < 12; w++) begin
      busB.in_lines[w*512 +: 512] = {16{w[31:0]}};
    end
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;

    checkOutput("rst_valid", 512'(busA.out_valid), 512'd0);
    checkOutput("rst_ready", 512'(busA.in_ready), 512'd1);
    checkOutput("rst_line", busA.out_line, 512'd0);
    checkOutput("rst_way", 512'(busA.out_way), 512'd0);
    checkOutput("rst_err", 512'(busA.out_err), 512'd0);

    // Single request, latency one cycle.
    busA.in_sel = 4'd5; busA.in_valid = 1'b1;
    applyStimulus();
    busA.in_valid = 1'b0;
    checkOutput("t1_valid", 512'(busA.out_valid), 512'd1);
    checkOutput("t1_line", busA.out_line, {16{32'd5}});
    checkOutput("t1_way", 512'(busA.out_way), 512'd5);
    checkOutput("t1_err", 512'(busA.out_err), 512'd0);
    applyStimulus();
    checkOutput("t1_drain", 512'(busA.out_valid), 512'd0);

    // Back-to-back streaming at one per cycle.
    busA.in_valid = 1'b1; busA.in_sel = 4'd7;
    applyStimulus();
    busA.in_sel = 4'd9;
    checkOutput("stream_way7", 512'(busA.out_way), 512'd7);
    applyStimulus();
    busA.in_valid = 1'b0;
    checkOutput("stream_way9", 512'(busA.out_way), 512'd9);
    checkOutput("stream_line9", busA.out_line, {16{32'd9}});
    applyStimulus();
    checkOutput("stream_drain", 512'(busA.out_valid), 512'd0);

    // Fill under backpressure, then drain in order.
    busA.out_ready = 1'b0;
    busA.in_valid = 1'b1; busA.in_sel = 4'd1;
    applyStimulus();
    checkOutput("t2_ready1", 512'(busA.in_ready), 512'd1);
    busA.in_sel = 4'd2;
    applyStimulus();
    checkOutput("t2_full", 512'(busA.in_ready), 512'd0);
    checkOutput("t2_head1", 512'(busA.out_way), 512'd1);
    busA.in_sel = 4'd3;
    applyStimulus();
    checkOutput("t2_stall_ready", 512'(busA.in_ready), 512'd0);
    checkOutput("t2_stall_way", 512'(busA.out_way), 512'd1);
    checkOutput("t2_stall_line", busA.out_line, {16{32'd1}});
    busA.out_ready = 1'b1;
    applyStimulus();
    checkOutput("t2_resp2", 512'(busA.out_way), 512'd2);
    checkOutput("t2_ready_back", 512'(busA.in_ready), 512'd1);
    applyStimulus();
    busA.in_valid = 1'b0;
    checkOutput("t2_resp3", 512'(busA.out_way), 512'd3);
    checkOutput("t2_resp3_valid", 512'(busA.out_valid), 512'd1);
    applyStimulus();
    checkOutput("t2_empty", 512'(busA.out_valid), 512'd0);

    // Binary select beyond WAYS=12, then the top legal way.
    busB.in_valid = 1'b1; busB.in_sel = 4'd13;
    applyStimulus();
    busB.in_sel = 4'd11;
    checkOutput("t3_err", 512'(busB.out_err), 512'd1);
    checkOutput("t3_err_line", busB.out_line, 512'd0);
    checkOutput("t3_err_way", 512'(busB.out_way), 512'd0);
    checkOutput("t3_err_valid", 512'(busB.out_valid), 512'd1);
    applyStimulus();
    busB.in_valid = 1'b0;
    checkOutput("t3_way11", 512'(busB.out_way), 512'd11);
    checkOutput("t3_line11", busB.out_line, {16{32'd11}});
    checkOutput("t3_ok11", 512'(busB.out_err), 512'd0);
    applyStimulus();

    // One-hot decode: two illegal patterns, then bits 8 and 15.
    busC.in_valid = 1'b1; busC.in_sel = 16'h0081;
    applyStimulus();
    busC.in_sel = 16'h0000;
    checkOutput("t4_multi_err", 512'(busC.out_err), 512'd1);
    checkOutput("t4_multi_line", busC.out_line, 512'd0);
    applyStimulus();
    busC.in_sel = 16'h0100;
    checkOutput("t4_zero_err", 512'(busC.out_err), 512'd1);
    applyStimulus();
    busC.in_sel = 16'h8000;
    checkOutput("t4_way8", 512'(busC.out_way), 512'd8);
    checkOutput("t4_ok8", 512'(busC.out_err), 512'd0);
    checkOutput("t4_line8", busC.out_line, {16{32'd8}});
    applyStimulus();
    busC.in_valid = 1'b0;
    checkOutput("t4_way15", 512'(busC.out_way), 512'd15);
    applyStimulus();

    // Reset while the buffer is full drops both entries.
    busA.out_ready = 1'b0;
    busA.in_valid = 1'b1; busA.in_sel = 4'd4;
    applyStimulus();
    busA.in_sel = 4'd6;
    applyStimulus();
    busA.in_valid = 1'b0;
    checkOutput("t5_full", 512'(busA.in_ready), 512'd0);
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    checkOutput("t5_valid", 512'(busA.out_valid), 512'd0);
    checkOutput("t5_ready", 512'(busA.in_ready), 512'd1);
    checkOutput("t5_line", busA.out_line, 512'd0);
    busA.out_ready = 1'b1;
    busA.in_valid = 1'b1; busA.in_sel = 4'd2;
    applyStimulus();
    busA.in_valid = 1'b0;
    checkOutput("t5_after_way", 512'(busA.out_way), 512'd2);
    applyStimulus();

`ifdef LWS_PARITY_EN
    checkOutput("t6_empty_par", 512'(busB.out_parity), 512'd0);
    busB.in_lines[511:0] = '0;
    busB.in_lines[3] = 1'b1;
    busB.in_lines[1023:512] = '1;
    busB.in_valid = 1'b1; busB.in_sel = 4'd0;
    applyStimulus();
    busB.in_sel = 4'd1;
    checkOutput("t6_par_one", 512'(busB.out_parity), 512'd1);
    applyStimulus();
    busB.in_sel = 4'd12;
    checkOutput("t6_par_ones", 512'(busB.out_parity), 512'd0);
    applyStimulus();
    busB.in_valid = 1'b0;
    checkOutput("t6_par_err", 512'(busB.out_parity), 512'd0);
    applyStimulus();
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
